vscale_htif_mailbox: RTL
========================

# vscale_htif_mailbox

Target-side tohost/fromhost mailbox on the vscale data-memory port. Core stores to the tohost word are queued in a small FIFO and drained by the host through a valid/ready handshake. The host delivers a single fromhost word that the core polls and consumes with a read. It sits beside the data memory in the simulation top and decodes its own address window.

## Interface
- BASE_ADDR, 32'h00001000: byte address of the 16-byte window; bits [3:0] must be zero.
- FIFO_DEPTH, 4: tohost FIFO entries; power of two, 2..16.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low.
- dmem_en  in  1  core request valid this cycle.
- dmem_write  in  1  1 = store, 0 = load; qualified by dmem_en.
- dmem_addr  in  32  byte address; the block responds only when dmem_addr[31:4] == BASE_ADDR[31:4].
- dmem_wdata  in  32  store data.
- dmem_rdata  out  32  load data, registered, valid the cycle after the load.
- dmem_stall  out  1  combinational; core must hold the request while high.
- tohost_valid  out  1  FIFO non-empty.
- tohost_data  out  32  FIFO head; stable while tohost_valid && !tohost_ready.
- tohost_ready  in  1  host pops the head when high with tohost_valid.
- fromhost_valid  in  1  host offers fromhost_data.
- fromhost_data  in  32  word from the host.
- fromhost_ready  out  1  fromhost register empty.

## Operation
- Register map (offset = dmem_addr[3:2]):
  - 0: TOHOST. Write pushes wdata. Read returns 0.
  - 1: FROMHOST. Read returns the held word and clears it. Write is ignored.
  - 2: STATUS, read-only:
    - bit0 = fromhost_full
    - bits[8:4] = tohost count
    - bit12 = overflow_seen
  - 3: reserved. Reads return 0, writes are ignored.
- Tohost FIFO: circular buffer with rd_ptr, wr_ptr and a count of log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
  - Push condition: dmem_en && dmem_write && hit && offset==0 && count<FIFO_DEPTH.
  - Pop condition: tohost_valid && tohost_ready.
  - Push and pop in the same cycle leave count unchanged, and both pointers advance.
  - Full is evaluated on the pre-pop count. A push while full stalls even if a pop occurs that cycle; the push completes on the next cycle.
- dmem_stall = dmem_en && dmem_write && hit && offset==0 && count==FIFO_DEPTH. There is no other stall source.
- overflow_seen is a sticky flag set on the first cycle dmem_stall is high. It clears only on reset.
- Fromhost register: a data word plus a fromhost_full flag.
  - fromhost_ready = !fromhost_full.
  - Host write happens when fromhost_valid && fromhost_ready: data is latched and full is set.
  - A core read of offset 1 while full clears full. A read while empty returns 0 and changes nothing.
  - Host accept and core clear are mutually exclusive: accept requires empty, clear requires full.
- Loads outside the window are not driven by this block; dmem_rdata is 0 the next cycle.
- Byte/halfword stores to offset 0 push the full 32-bit wdata; the block does not interpret byte enables.

## Timing
- Reset (reset==0 at posedge) sets:
  - count=0, rd_ptr=0, wr_ptr=0
  - fromhost_full=0, fromhost data=0
  - overflow_seen=0
  - dmem_rdata=0
- After reset the outputs are tohost_valid=0, tohost_data=0, fromhost_ready=1, dmem_stall=0.
- Reset mid-operation discards FIFO contents and any held fromhost word. No handshake completes in the reset cycle.
- Push latency: a store at cycle N makes tohost_valid high at N+1, with the word at the head if the FIFO was empty.
- Load latency: dmem_rdata is valid at N+1 for a load at N.
  - The STATUS value reflects state before cycle N's updates.
  - A FROMHOST read at N returns the word, and fromhost_ready rises at N+1.
- Host write at N: a STATUS read at N+1 shows bit0=1.
- Throughput: one push and one pop per cycle are sustained indefinitely.

## Test plan
- Reset then idle:
  - tohost_valid=0, fromhost_ready=1, dmem_stall=0.
  - A load of BASE+8 returns 0.
- Store 32'h1 to BASE with tohost_ready=1:
  - tohost_valid=1 and tohost_data=1 at N+1, popped at N+1.
  - Count returns to 0 at N+2.
- Five stores 10,11,12,13,14 with tohost_ready=0, FIFO_DEPTH=4:
  - The fifth store stalls, and STATUS reads count=4 with bit12=1.
  - Raising ready for one cycle pops 10, the stalled store completes the next cycle, and the drain order is 11,12,13,14.
- FIFO_DEPTH=4, push and pop every cycle for 20 cycles with data 0..19:
  - The host receives 0..19 in order across pointer wrap, and count stays ≤1.
- Host offers 32'hCAFE:
  - fromhost_ready falls the next cycle, and STATUS bit0=1.
  - A load of BASE+4 returns 32'hCAFE, and fromhost_ready=1 the following cycle.
  - A second load returns 0.
- Assert reset for one cycle with 3 words queued and fromhost full:
  - Afterwards count=0, tohost_valid=0, fromhost_ready=1, overflow_seen=0.

Source files
------------

// File: rtl/vscale_htif_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : vscale_htif_mailbox
// Description : Target-side tohost/fromhost mailbox on the vscale data-memory
//               port. Core stores to TOHOST are queued in a small FIFO and
//               drained by the host with a valid/ready handshake. The host
//               delivers one FROMHOST word that the core polls and consumes.
//               The block decodes its own 16-byte window at BASE_ADDR.
// Ports       :
//   clk, reset                      clock, synchronous active-low reset
//   dmem_en/write/addr/wdata        core data-memory request
//   dmem_rdata                      registered load data (cycle after load)
//   dmem_stall                      combinational, TOHOST store while full
//   tohost_valid/data, tohost_ready FIFO head towards the host
//   fromhost_valid/data             word offered by the host
//   fromhost_ready                  fromhost register empty
// Register map (offset = dmem_addr[3:2]):
//   0 TOHOST (W push, R 0)   1 FROMHOST (R and clear)
//   2 STATUS {bit12 overflow_seen, bits[8:4] count, bit0 fromhost_full}
//   3 reserved
// Revision    : 1.0 - initial release
// ============================================================================
module vscale_htif_mailbox #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_write,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_stall,
  output logic        tohost_valid,
  output logic [31:0] tohost_data,
  input  logic        tohost_ready,
  input  logic        fromhost_valid,
  input  logic [31:0] fromhost_data,
  output logic        fromhost_ready
);

  localparam int                 c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(FIFO_DEPTH);
  localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               r_fh_full;
  logic [31:0]        r_fh_data;
  logic               r_overflow;
  logic [31:0]        r_rdata;

  // --------------------------------------------------------------------------
  // Address decode and handshakes
  // --------------------------------------------------------------------------
  logic        w_hit;
  logic [1:0]  w_off;
  logic        w_push_req;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_load;
  logic        w_fh_accept;
  logic        w_fh_clear;
  logic [4:0]  w_count5;
  logic [31:0] w_status;
  logic [31:0] w_rdata_next;
  logic        w_unused_ok;

  assign w_hit      = (dmem_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off      = dmem_addr[3:2];
  assign w_push_req = dmem_en && dmem_write && w_hit && (w_off == 2'd0);
  // Full is judged on the pre-pop count, so a push against a full FIFO
  // stalls even when the host pops in the same cycle.
  assign w_full     = (r_count == c_depth);
  assign w_push     = w_push_req && !w_full;
  assign w_pop      = tohost_valid && tohost_ready;
  assign w_load     = dmem_en && !dmem_write && w_hit;

  // Accept needs an empty register and clear needs a full one, so the two
  // can never coincide.
  assign w_fh_accept = fromhost_valid && !r_fh_full;
  assign w_fh_clear  = w_load && (w_off == 2'd1) && r_fh_full;

  assign w_count5 = 5'(r_count);
  assign w_status = {19'd0, r_overflow, 3'd0, w_count5, 3'd0, r_fh_full};

  // Byte lanes are not interpreted; the low address bits are don't-care.
  assign w_unused_ok = &{1'b0, dmem_addr[1:0]};

  always_comb begin
    w_rdata_next = '0;
    if (w_load) begin
      case (w_off)
        2'd1:    w_rdata_next = r_fh_full ? r_fh_data : 32'd0;
        2'd2:    w_rdata_next = w_status;
        default: w_rdata_next = '0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Tohost FIFO
  // --------------------------------------------------------------------------
  // Storage is not reset; the head is masked to zero while empty so stale
  // entries never appear on tohost_data.
  always_ff @(posedge clk) begin
    if (w_push && reset) begin
      r_mem[r_wr_ptr] <= dmem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Fromhost register, sticky overflow flag and load data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fh_full  <= 1'b0;
      r_fh_data  <= '0;
      r_overflow <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (w_fh_accept) begin
        r_fh_full <= 1'b1;
        r_fh_data <= fromhost_data;
      end else if (w_fh_clear) begin
        r_fh_full <= 1'b0;
      end
      if (dmem_stall) r_overflow <= 1'b1;
      r_rdata <= w_rdata_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign dmem_stall     = w_push_req && w_full;
  assign dmem_rdata     = r_rdata;
  assign tohost_valid   = (r_count != '0);
  assign tohost_data    = tohost_valid ? r_mem[r_rd_ptr] : 32'd0;
  assign fromhost_ready = !r_fh_full;

endmodule
`default_nettype wire
